dac_request_scheduler: RTL and testbench

- Round-robin scheduler that shares the single SPI DAC serializer among NUM_CH channel requesters.
- Builds the 28-bit DAC command word, drives go_DAC, and tracks the serializer's trans flag to detect frame start and end.
- Returns a one-cycle ack to the winning requester and flags stalled transfers with a timeout.
- Sits between channel-level waveform/setpoint logic and the SPI interface block.

---
 rtl/dac_request_scheduler.sv | 112 +++++++++++
 tb/tb_dac_request_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_request_scheduler.sv
// dac_request_scheduler: round-robin arbiter sharing one SPI DAC serializer among four channel requesters
module dac_request_scheduler #(
  parameter int          NUM_CH   = 4,
  parameter logic [3:0]  CMD      = 4'b0011,
  parameter int          START_TO = 15,
  parameter int          DONE_TO  = 127
) (
  input  logic                 clk,
  input  logic                 reset_Async,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    req,
  input  logic [12*NUM_CH-1:0] req_data,
  input  logic                 trans,
  output logic                 go_DAC,
  output logic [27:0]          DAC_in,
  output logic [NUM_CH-1:0]    ack,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 timeout,
  output logic                 err
);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, ACK} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, win, gid_n;
  logic found, go_n, to_n, err_n;
  logic [7:0] cnt, cnt_n;
  logic [27:0] dac_n;
  logic [NUM_CH-1:0] ack_n;
  // first requester after the last acked channel; scanning downward leaves the nearest one
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = NUM_CH; k >= 1; k--)
      if (req[ptr + 2'(k)]) begin
        win = ptr + 2'(k);
        found = 1'b1;
      end
  end
  // next state and next registered outputs; timeouts leave ptr alone so the stalled channel retries first
  always_comb begin
    state_n = state;
    go_n = go_DAC;
    dac_n = DAC_in;
    ack_n = '0;
    gid_n = grant_id;
    to_n = 1'b0;
    err_n = err;
    ptr_n = ptr;
    cnt_n = cnt;
    case (state)
      IDLE:
        if (enable && found) begin
          state_n = WAIT_START;
          gid_n = win;
          dac_n = {CMD, 2'b00, win, req_data[12*win +: 12], 8'h00};
          go_n = 1'b1;
          cnt_n = '0;
        end
      WAIT_START:
        if (trans) begin
          state_n = WAIT_DONE;
          go_n = 1'b0;
          cnt_n = '0;
        end else if (cnt == 8'(START_TO)) begin
          state_n = IDLE;
          go_n = 1'b0;
          to_n = 1'b1;
          err_n = 1'b1;
        end else cnt_n = cnt + 8'd1;
      WAIT_DONE:
        if (!trans) begin
          state_n = ACK;
          ack_n[grant_id] = 1'b1;
        end else if (cnt == 8'(DONE_TO)) begin
          state_n = IDLE;
          to_n = 1'b1;
          err_n = 1'b1;
        end else cnt_n = cnt + 8'd1;
      ACK: begin
        state_n = IDLE;
        ptr_n = grant_id;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; ptr resets to 3 so channel 0 is scanned first
  always_ff @(posedge clk or negedge reset_Async) begin
    if (!reset_Async) begin
      state <= IDLE;
      go_DAC <= 1'b0;
      DAC_in <= '0;
      ack <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      err <= 1'b0;
      ptr <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_n;
      go_DAC <= go_n;
      DAC_in <= dac_n;
      ack <= ack_n;
      grant_id <= gid_n;
      busy <= state_n != IDLE;
      timeout <= to_n;
      err <= err_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_dac_request_scheduler.sv
// tb_dac_request_scheduler: vector table, corner sequences and randomized run against a round-robin model
module tb_dac_request_scheduler;
  logic clk = 1'b0;
  logic reset_Async, enable, trans;
  logic [3:0] req;
  logic [47:0] req_data;
  logic go_DAC, busy, timeout, err;
  logic [27:0] DAC_in;
  logic [3:0] ack;
  logic [1:0] grant_id;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] code;
    logic [27:0] dac;
    logic [3:0]  ack;
  } vec_t;
  vec_t tbl[7];

  logic [3:0] a;
  logic [1:0] e, last;
  logic [27:0] exp_dac;
  logic exp_valid, go_prev;
  int n, age, grants, tos, phase, dly, len;

  always #5 clk = ~clk;

  dac_request_scheduler dut (
    .clk(clk), .reset_Async(reset_Async), .enable(enable), .req(req), .req_data(req_data),
    .trans(trans), .go_DAC(go_DAC), .DAC_in(DAC_in), .ack(ack), .grant_id(grant_id),
    .busy(busy), .timeout(timeout), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] cmd(input logic [1:0] ch, input logic [11:0] code);
    return {4'b0011, 2'b00, ch, code, 8'h00};
  endfunction

  // first pending channel after the last acked one, modulo 4
  function automatic logic [1:0] rr(input logic [1:0] lst, input logic [3:0] r);
    for (int i = 1; i <= 4; i++)
      if (r[(int'(lst) + i) % 4]) return 2'((int'(lst) + i) % 4);
    return lst;
  endfunction

  task automatic do_reset;
    reset_Async = 1'b0;
    req = '0;
    trans = 1'b0;
    tick;
    reset_Async = 1'b1;
    tick;
  endtask

  task automatic frame(output logic [3:0] ak);
    int k = 0;
    do begin
      tick;
      k++;
    end while (!go_DAC && k < 20);
    chk("frame_go", 32'(go_DAC), 1);
    trans = 1'b1;
    tick;
    trans = 1'b0;
    tick;
    ak = ack;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0100, 12'hABC, 28'h32ABC00, 4'b0100};
    tbl[1] = '{4'b0101, 12'h123, 28'h3012300, 4'b0001};
    tbl[2] = '{4'b0101, 12'hFFF, 28'h32FFF00, 4'b0100};
    tbl[3] = '{4'b1111, 12'h000, 28'h3300000, 4'b1000};
    tbl[4] = '{4'b1010, 12'h5A5, 28'h315A500, 4'b0010};
    tbl[5] = '{4'b0010, 12'h001, 28'h3100100, 4'b0010};
    tbl[6] = '{4'b1000, 12'h800, 28'h3380000, 4'b1000};
    reset_Async = 1'b0;
    enable = 1'b0;
    trans = 1'b0;
    req = '0;
    req_data = '0;
    tick;
    chk("rst_go", 32'(go_DAC), 0);
    chk("rst_dac", 32'(DAC_in), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(timeout), 0);
    chk("rst_err", 32'(err), 0);
    reset_Async = 1'b1;
    enable = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      req_data = {4{tbl[i].code}};
      tick;
      chk("tbl_go", 32'(go_DAC), 1);
      chk("tbl_dac", 32'(DAC_in), 32'(tbl[i].dac));
      chk("tbl_busy", 32'(busy), 1);
      req_data = ~req_data;
      tick;
      chk("tbl_hold_go", 32'(go_DAC), 1);
      chk("tbl_hold_dac", 32'(DAC_in), 32'(tbl[i].dac));
      trans = 1'b1;
      tick;
      chk("tbl_go_drop", 32'(go_DAC), 0);
      tick;
      trans = 1'b0;
      tick;
      chk("tbl_ack", 32'(ack), 32'(tbl[i].ack));
      req = '0;
      tick;
      chk("tbl_ack_pulse", 32'(ack), 0);
      chk("tbl_idle", 32'(busy), 0);
    end
    req = 4'b0010;
    tick;
    n = 0;
    while (go_DAC && n < 40) begin
      n++;
      tick;
    end
    chk("st_go_cycles", 32'(n), 16);
    chk("st_timeout", 32'(timeout), 1);
    chk("st_err", 32'(err), 1);
    chk("st_no_ack", 32'(ack), 0);
    chk("st_idle", 32'(busy), 0);
    tick;
    chk("st_regrant_go", 32'(go_DAC), 1);
    chk("st_regrant_gid", 32'(grant_id), 1);
    chk("st_to_pulse", 32'(timeout), 0);
    chk("st_err_sticky", 32'(err), 1);
    trans = 1'b1;
    tick;
    n = 0;
    while (!timeout && n < 300) begin
      n++;
      tick;
    end
    chk("dt_cycles", 32'(n), 128);
    chk("dt_idle", 32'(busy), 0);
    chk("dt_err", 32'(err), 1);
    chk("dt_no_ack", 32'(ack), 0);
    trans = 1'b0;
    req = '0;
    tick;
    chk("dt_to_pulse", 32'(timeout), 0);
    enable = 1'b0;
    req = 4'b0001;
    tick;
    tick;
    tick;
    chk("en_no_go", 32'(go_DAC), 0);
    chk("en_no_busy", 32'(busy), 0);
    enable = 1'b1;
    req = 4'b0011;
    tick;
    chk("en_go", 32'(go_DAC), 1);
    chk("en_gid", 32'(grant_id), 0);
    enable = 1'b0;
    trans = 1'b1;
    tick;
    trans = 1'b0;
    tick;
    chk("en_ack", 32'(ack), 1);
    req = 4'b0010;
    tick;
    tick;
    tick;
    chk("en_no_regrant", 32'(busy), 0);
    chk("en_no_regrant_go", 32'(go_DAC), 0);
    req = '0;
    enable = 1'b1;
    req_data = 48'h123456789ABC;
    req = 4'b0100;
    tick;
    trans = 1'b1;
    tick;
    chk("ar_busy_before", 32'(busy), 1);
    reset_Async = 1'b0;
    #1;
    chk("ar_go", 32'(go_DAC), 0);
    chk("ar_dac", 32'(DAC_in), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_err", 32'(err), 0);
    trans = 1'b0;
    req = 4'b1001;
    #3;
    reset_Async = 1'b1;
    tick;
    chk("ar_go_after", 32'(go_DAC), 1);
    chk("ar_gid_after", 32'(grant_id), 0);
    chk("ar_dac_after", 32'(DAC_in), 32'(28'h30ABC00));
    trans = 1'b1;
    tick;
    trans = 1'b0;
    tick;
    chk("ar_ack", 32'(ack), 1);
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      frame(a);
      chk("rr_held", 32'(a), 32'(4'b0001 << (i % 4)));
    end
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      frame(a);
      chk("rr_drop", 32'(a), 32'(4'b0001 << i));
      req &= ~a;
    end
    tick;
    tick;
    chk("rr_drop_idle", 32'(busy), 0);
    do_reset;
    last = 2'd3;
    e = 2'd0;
    exp_dac = '0;
    exp_valid = 1'b0;
    go_prev = 1'b0;
    age = 0;
    grants = 0;
    tos = 0;
    phase = 0;
    dly = 0;
    len = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (timeout) tos++;
      if (go_DAC && !go_prev) begin
        e = rr(last, req);
        chk("rnd_enable", 32'(enable), 1);
        chk("rnd_gid", 32'(grant_id), 32'(e));
        exp_dac = cmd(e, req_data[12*e +: 12]);
        chk("rnd_dac", 32'(DAC_in), 32'(exp_dac));
        exp_valid = 1'b1;
        age = 0;
        grants++;
      end else if (busy && exp_valid) chk("rnd_hold", 32'(DAC_in), 32'(exp_dac));
      if (ack != 0) begin
        chk("rnd_ack", 32'(ack), exp_valid ? 32'(4'b0001 << e) : 0);
        req &= ~ack;
        last = e;
        exp_valid = 1'b0;
      end
      if (exp_valid) begin
        age++;
        if (age == 60) chk("rnd_stall", 32'(age), 0);
      end
      go_prev = go_DAC;
      enable = ($urandom % 8) != 0;
      req |= ($urandom % 4 == 0) ? 4'($urandom) : 4'b0000;
      req_data = {16'($urandom), $urandom};
      if (phase == 0) begin
        if (go_DAC && !trans) begin
          dly = $urandom_range(0, 5);
          phase = 1;
        end
      end else if (phase == 1) begin
        if (dly == 0) begin
          trans = 1'b1;
          len = $urandom_range(0, 10);
          phase = 2;
        end else dly--;
      end else begin
        if (len == 0) begin
          trans = 1'b0;
          phase = 0;
        end else len--;
      end
    end
    chk("rnd_no_timeout", 32'(tos), 0);
    chk("rnd_err", 32'(err), 0);
    chk("rnd_progress", 32'(grants > 50), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
